// File: rtl/mm_vdma_pkg.sv
// Shared AXI constants, FSM state encoding and helper functions for the
// stream-to-memory write path.
package mm_vdma_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_wr_addr_gen.sv
// Frame/line/burst address generator and burst-length calculator.
// Optional MM_WR_4K_SPLIT_EN clips each burst at the next 4 KB boundary.
module mm_wr_addr_gen
  import mm_vdma_pkg::*;
#(
  parameter int ASIZE      = 32,
  parameter int DSIZE      = 256,
  parameter int LSIZE      = 8,
  parameter int MAX_BURST  = 64,
  parameter int FRAME_BUFS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_frame,
  input  logic              burst_done,
  input  logic [ASIZE-1:0]  base_addr,
  input  logic [ASIZE-1:0]  frame_size,
  input  logic [15:0]       line_stride,
  input  logic [15:0]       line_beats,
  input  logic [15:0]       frame_lines,
  output logic [2:0]        buf_idx,
  output logic [ASIZE-1:0]  cur_addr,
  output logic [LSIZE:0]    len,
  output logic              last_burst
);

  localparam int BYTE_SHIFT = clog2(DSIZE / 8);
  localparam int LW         = 17;
  localparam int LENW       = LSIZE + 1;

  logic [2:0]       buf_idx_r;
  logic [2:0]       nxt_idx_s;
  logic [ASIZE-1:0] line_addr_r;
  logic [ASIZE-1:0] cur_addr_r;
  logic [15:0]      beats_left_r;
  logic [15:0]      lines_left_r;
  logic [LW-1:0]    cap_s;
  logic [LW-1:0]    len_full_s;
  logic             line_end_s;
`ifdef MM_WR_4K_SPLIT_EN
  logic [LW-1:0]    room_s;
`endif

  assign nxt_idx_s  = (buf_idx_r == 3'(FRAME_BUFS - 1)) ? 3'd0 : buf_idx_r + 3'd1;
  assign line_end_s = (LW'(beats_left_r) == len_full_s);
  assign last_burst = line_end_s && (lines_left_r == 16'd1);
  assign buf_idx    = buf_idx_r;
  assign cur_addr   = cur_addr_r;
  assign len        = LENW'(len_full_s);

  // Burst length: min of MAX_BURST, beats left in the line and (optionally) room to 4 KB.
  always_comb begin
    if (32'(beats_left_r) < 32'(MAX_BURST)) begin
      cap_s = LW'(beats_left_r);
    end else begin
      cap_s = LW'(MAX_BURST);
    end
`ifdef MM_WR_4K_SPLIT_EN
    room_s = LW'((13'h1000 - {1'b0, cur_addr_r[11:0]}) >> BYTE_SHIFT);
    if (room_s < cap_s) begin
      len_full_s = room_s;
    end else begin
      len_full_s = cap_s;
    end
`else
    len_full_s = cap_s;
`endif
  end

  // Address/counter registers: reload on a new frame, advance on each burst response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_idx_r    <= 3'(FRAME_BUFS - 1);
      line_addr_r  <= {ASIZE{1'b0}};
      cur_addr_r   <= {ASIZE{1'b0}};
      beats_left_r <= 16'd0;
      lines_left_r <= 16'd0;
    end else if (load_frame) begin
      buf_idx_r    <= nxt_idx_s;
      line_addr_r  <= base_addr + ASIZE'(nxt_idx_s) * frame_size;
      cur_addr_r   <= base_addr + ASIZE'(nxt_idx_s) * frame_size;
      beats_left_r <= line_beats;
      lines_left_r <= frame_lines;
    end else if (burst_done) begin
      if (line_end_s) begin
        line_addr_r  <= line_addr_r + ASIZE'(line_stride);
        cur_addr_r   <= line_addr_r + ASIZE'(line_stride);
        beats_left_r <= line_beats;
        lines_left_r <= lines_left_r - 16'd1;
      end else begin
        cur_addr_r   <= cur_addr_r + (ASIZE'(len_full_s) << BYTE_SHIFT);
        beats_left_r <= beats_left_r - 16'(len_full_s);
      end
    end
  end

endmodule

// File: rtl/mm_wr_burst_engine.sv
// AXI4 write master draining an FWFT line FIFO into multi-buffered frames.
// Build option MM_WR_4K_SPLIT_EN enables 4 KB burst splitting in mm_wr_addr_gen.
module mm_wr_burst_engine
  import mm_vdma_pkg::*;
#(
  parameter int DSIZE      = 256,
  parameter int ASIZE      = 32,
  parameter int IDSIZE     = 3,
  parameter int ID         = 0,
  parameter int LSIZE      = 8,
  parameter int MAX_BURST  = 64,
  parameter int CSIZE      = 10,
  parameter int FRAME_BUFS = 3
) (
  input  logic               axi_aclk,
  input  logic               axi_resetn,
  input  logic               enable,
  input  logic [ASIZE-1:0]   base_addr,
  input  logic [ASIZE-1:0]   frame_size,
  input  logic [15:0]        line_stride,
  input  logic [15:0]        line_beats,
  input  logic [15:0]        frame_lines,
  input  logic               frame_start,
  input  logic [CSIZE-1:0]   fifo_count,
  input  logic [DSIZE-1:0]   fifo_dout,
  output logic               fifo_rd_en,
  output logic [IDSIZE-1:0]  axi_awid,
  output logic [ASIZE-1:0]   axi_awaddr,
  output logic [LSIZE-1:0]   axi_awlen,
  output logic [2:0]         axi_awsize,
  output logic [1:0]         axi_awburst,
  output logic               axi_awlock,
  output logic [3:0]         axi_awcache,
  output logic [2:0]         axi_awprot,
  output logic [3:0]         axi_awqos,
  output logic               axi_awvalid,
  input  logic               axi_awready,
  output logic [DSIZE-1:0]   axi_wdata,
  output logic [DSIZE/8-1:0] axi_wstrb,
  output logic               axi_wlast,
  output logic               axi_wvalid,
  input  logic               axi_wready,
  input  logic [IDSIZE-1:0]  axi_bid,
  input  logic [1:0]         axi_bresp,
  input  logic               axi_bvalid,
  output logic               axi_bready,
  output logic [2:0]         buf_idx,
  output logic               frame_done,
  output logic               wr_err
);

  localparam int LENW = LSIZE + 1;

  state_t           state_r;
  logic             pending_r;
  logic             active_r;
  logic             awvalid_r;
  logic [ASIZE-1:0] awaddr_r;
  logic [LSIZE-1:0] awlen_r;
  logic             wvalid_r;
  logic             wlast_r;
  logic             bready_r;
  logic [LSIZE-1:0] beat_cnt_r;
  logic             frame_done_r;
  logic             wr_err_r;
  logic             load_frame_s;
  logic             burst_done_s;
  logic [ASIZE-1:0] cur_addr_s;
  logic [LSIZE:0]   len_s;
  logic             last_burst_s;
  logic             unused_bid_s;

  assign load_frame_s = (state_r == ST_IDLE) && pending_r;
  assign burst_done_s = (state_r == ST_RESP) && axi_bvalid;
  assign unused_bid_s = ^axi_bid;

  mm_wr_addr_gen #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
    .MAX_BURST(MAX_BURST), .FRAME_BUFS(FRAME_BUFS)
  ) u_addr_gen (
    .clk(axi_aclk), .rst_n(axi_resetn),
    .load_frame(load_frame_s), .burst_done(burst_done_s),
    .base_addr(base_addr), .frame_size(frame_size), .line_stride(line_stride),
    .line_beats(line_beats), .frame_lines(frame_lines),
    .buf_idx(buf_idx), .cur_addr(cur_addr_s), .len(len_s), .last_burst(last_burst_s)
  );

  assign axi_awid    = IDSIZE'(ID);
  assign axi_awsize  = 3'(clog2(DSIZE / 8));
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = CACHE_DEFAULT;
  assign axi_awprot  = 3'd0;
  assign axi_awqos   = 4'd0;
  assign axi_awvalid = awvalid_r;
  assign axi_awaddr  = awaddr_r;
  assign axi_awlen   = awlen_r;
  assign axi_wdata   = fifo_dout;
  assign axi_wstrb   = {(DSIZE/8){1'b1}};
  assign axi_wvalid  = wvalid_r;
  assign axi_wlast   = wlast_r;
  assign axi_bready  = bready_r;
  assign fifo_rd_en  = wvalid_r & axi_wready;
  assign frame_done  = frame_done_r;
  assign wr_err      = wr_err_r;

  // Burst FSM with registered AXI handshake outputs; one burst outstanding at a time.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r      <= ST_IDLE;
      pending_r    <= 1'b0;
      active_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      awaddr_r     <= {ASIZE{1'b0}};
      awlen_r      <= {LSIZE{1'b0}};
      wvalid_r     <= 1'b0;
      wlast_r      <= 1'b0;
      bready_r     <= 1'b0;
      beat_cnt_r   <= {LSIZE{1'b0}};
      frame_done_r <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (frame_start) begin
        pending_r <= 1'b1;
      end else if (load_frame_s) begin
        pending_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (load_frame_s) begin
            active_r <= 1'b1;
          end else if (enable && active_r && (32'(fifo_count) >= 32'(len_s))) begin
            awvalid_r <= 1'b1;
            awaddr_r  <= cur_addr_s;
            awlen_r   <= LSIZE'(len_s - LENW'(1'b1));
            state_r   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi_awready) begin
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b1;
            wlast_r    <= (awlen_r == {LSIZE{1'b0}});
            beat_cnt_r <= {LSIZE{1'b0}};
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi_wready) begin
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_RESP;
            end else begin
              beat_cnt_r <= beat_cnt_r + LSIZE'(1'b1);
              wlast_r    <= ((beat_cnt_r + LSIZE'(1'b1)) == awlen_r);
            end
          end
        end
        ST_RESP: begin
          if (axi_bvalid) begin
            bready_r <= 1'b0;
            state_r  <= ST_IDLE;
            if (axi_bresp != RESP_OKAY) begin
              wr_err_r <= 1'b1;
            end
            if (last_burst_s) begin
              frame_done_r <= 1'b1;
              active_r     <= 1'b0;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_wr_burst_engine.sv
// Self-checking bench for mm_wr_burst_engine: vector table, corner sequences and
// randomized frames checked against a burst-list reference model.
module tb_mm_wr_burst_engine;

  logic         clk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic         enable = 1'b0;
  logic [31:0]  base_addr = 32'd0;
  logic [31:0]  frame_size = 32'd0;
  logic [15:0]  line_stride = 16'd0;
  logic [15:0]  line_beats = 16'd1;
  logic [15:0]  frame_lines = 16'd1;
  logic         frame_start = 1'b0;
  logic [9:0]   fifo_count = 10'd0;
  logic [255:0] fifo_dout = 256'd0;
  logic         fifo_rd_en;
  logic [2:0]   axi_awid;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awlock;
  logic [3:0]   axi_awcache;
  logic [2:0]   axi_awprot;
  logic [3:0]   axi_awqos;
  logic         axi_awvalid;
  logic         axi_awready = 1'b0;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready = 1'b0;
  logic [2:0]   axi_bid = 3'd0;
  logic [1:0]   axi_bresp = 2'b00;
  logic         axi_bvalid = 1'b0;
  logic         axi_bready;
  logic [2:0]   buf_idx;
  logic         frame_done;
  logic         wr_err;

  mm_wr_burst_engine dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn), .enable(enable),
    .base_addr(base_addr), .frame_size(frame_size), .line_stride(line_stride),
    .line_beats(line_beats), .frame_lines(frame_lines), .frame_start(frame_start),
    .fifo_count(fifo_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .buf_idx(buf_idx), .frame_done(frame_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          last;
  } burst_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] beats;
    logic [15:0] lines;
    logic [2:0]  idx;
    logic [31:0] first_addr;
    int          first_awlen;
    int          bursts;
  } vec_t;

  int tests = 0;
  int failed = 0;

  burst_t      exp_q[$];
  logic [31:0] aw_log_addr[$];
  int          aw_log_len[$];
  int          model_idx = 2;

  // slave / monitor controls and state
  bit aw_allow = 1'b1;
  bit aw_rand = 1'b0;
  bit b_rand = 1'b0;
  int wr_mode = 0;
  int fifo_mode = 0;
  int fifo_fill = 0;
  int err_at = -1;
  int word = 0;
  int pops = 0;
  int beat = 0;
  int cur_len = 1;
  bit cur_last = 1'b0;
  bit b_pend = 1'b0;
  bit b_taken = 1'b0;
  int b_wait = 0;
  int b_count = 0;
  bit exp_fd = 1'b0;
  int fd_count = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference model: expand one frame into its burst list from the addressing rules.
  task automatic model_frame();
    logic [31:0] a;
    int left;
    int n;
    model_idx = (model_idx + 1) % 3;
    for (int l = 0; l < int'(frame_lines); l++) begin
      a = base_addr + 32'(model_idx) * frame_size + 32'(l) * 32'(line_stride);
      left = int'(line_beats);
      while (left > 0) begin
        n = (left < 64) ? left : 64;
`ifdef MM_WR_4K_SPLIT_EN
        if ((4096 - int'(a % 4096)) / 32 < n) n = (4096 - int'(a % 4096)) / 32;
`endif
        exp_q.push_back('{addr: a, len: n, last: (l == int'(frame_lines) - 1) && (left == n)});
        a = a + 32'(n * 32);
        left = left - n;
      end
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (fd_count < target && n < 6000) begin
      cyc();
      n++;
    end
    chk(name, fd_count >= target, 1'b1);
  endtask

  // AXI slave, FIFO emulation and protocol monitor, sampled mid-cycle.
  task automatic monitor();
    bit aw_hs, w_hs, b_hs;
    int lvl;
    burst_t e;
    forever begin
      @(negedge clk);
      if (b_taken) begin
        axi_bvalid = 1'b0;
        b_taken = 1'b0;
      end
      if (!axi_resetn) begin
        b_pend = 1'b0;
        axi_bvalid = 1'b0;
        beat = 0;
        exp_fd = 1'b0;
      end else begin
        axi_awready = aw_allow && (!aw_rand || ($urandom_range(0, 2) == 0));
        case (wr_mode)
          0: axi_wready = 1'b1;
          1: axi_wready = ~axi_wready;
          default: axi_wready = ($urandom_range(0, 1) == 1);
        endcase
        if (b_pend && !axi_bvalid) begin
          if (b_wait == 0) begin
            axi_bvalid = 1'b1;
            axi_bresp = (b_count == err_at) ? 2'b10 : 2'b00;
          end else begin
            b_wait--;
          end
        end
        lvl = fifo_fill - word;
        if (lvl < 0) lvl = 0;
        if (lvl > 1023) lvl = 1023;
        case (fifo_mode)
          0: fifo_count = 10'd1023;
          1: fifo_count = 10'(lvl);
          default: fifo_count = 10'($urandom_range(0, 100));
        endcase
        fifo_dout = {8{32'(word)}};
      end
      #1;
      if (axi_resetn) begin
        aw_hs = axi_awvalid && axi_awready;
        w_hs  = axi_wvalid && axi_wready;
        b_hs  = axi_bvalid && axi_bready;
        chk("fifo_rd_en", fifo_rd_en, w_hs);
        chk("frame_done", frame_done, exp_fd);
        if (frame_done) fd_count++;
        exp_fd = 1'b0;
        if (aw_hs) begin
          aw_log_addr.push_back(axi_awaddr);
          aw_log_len.push_back(int'(axi_awlen));
          cur_len = int'(axi_awlen) + 1;
          beat = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected AW", 1'b1, 1'b0);
            cur_last = 1'b0;
          end else begin
            e = exp_q.pop_front();
            chk("awaddr", axi_awaddr, e.addr);
            chk("awlen", axi_awlen, 8'(e.len - 1));
            cur_last = e.last;
          end
        end
        if (w_hs) begin
          chk("wlast", axi_wlast, beat == cur_len - 1);
          chk("wdata", axi_wdata, {8{32'(word)}});
          beat++;
          word++;
          pops++;
          if (axi_wlast) begin
            beat = 0;
            b_pend = 1'b1;
            b_wait = b_rand ? $urandom_range(0, 3) : 0;
          end
        end
        if (b_hs) begin
          b_taken = 1'b1;
          b_pend = 1'b0;
          b_count++;
          exp_fd = cur_last;
        end
      end
    end
  endtask

  vec_t vt[5];
  int   aw0, fd0, p0, n;

  initial begin
    vt[0] = '{32'h0010_0000, 16'h1000, 16'd100, 16'd2, 3'd0, 32'h0010_0000, 63, 4};
    vt[1] = '{32'h0010_0000, 16'h0040, 16'd2,   16'd3, 3'd1, 32'h0014_0000, 1,  3};
`ifdef MM_WR_4K_SPLIT_EN
    vt[2] = '{32'h0018_0FC0, 16'h1000, 16'd64,  16'd1, 3'd2, 32'h0020_0FC0, 1,  2};
`else
    vt[2] = '{32'h0018_0FC0, 16'h1000, 16'd64,  16'd1, 3'd2, 32'h0020_0FC0, 63, 1};
`endif
    vt[3] = '{32'h0030_0000, 16'h0020, 16'd1,   16'd1, 3'd0, 32'h0030_0000, 0,  1};
    vt[4] = '{32'h0040_0000, 16'h2000, 16'd130, 16'd1, 3'd1, 32'h0044_0000, 63, 3};

    fork
      monitor();
    join_none

    repeat (3) cyc();
    chk("rst awvalid", axi_awvalid, 1'b0);
    chk("rst wvalid", axi_wvalid, 1'b0);
    chk("rst bready", axi_bready, 1'b0);
    chk("rst fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst wr_err", wr_err, 1'b0);
    chk("rst buf_idx", buf_idx, 3'd2);
    chk("awsize", axi_awsize, 3'd5);
    chk("awburst", axi_awburst, 2'b01);
    chk("awcache", axi_awcache, 4'b0011);
    chk("awid/lock/prot/qos", {axi_awid, axi_awlock, axi_awprot, axi_awqos}, 11'd0);
    chk("wstrb", axi_wstrb, 32'hFFFF_FFFF);
    axi_resetn = 1'b1;
    cyc();
    enable = 1'b1;
    frame_size = 32'h0004_0000;

    for (int i = 0; i < 5; i++) begin
      base_addr = vt[i].base;
      line_stride = vt[i].stride;
      line_beats = vt[i].beats;
      frame_lines = vt[i].lines;
      wr_mode = i % 3;
      aw_rand = (i % 2) == 1;
      b_rand = (i % 2) == 0;
      aw0 = aw_log_addr.size();
      fd0 = fd_count;
      model_frame();
      pulse_frame();
      wait_frames(fd0 + 1, "vec frame_done timeout");
      chk("vec buf_idx", buf_idx, vt[i].idx);
      chk("vec burst count", aw_log_addr.size() - aw0, vt[i].bursts);
      if (aw_log_addr.size() > aw0) begin
        chk("vec first awaddr", aw_log_addr[aw0], vt[i].first_addr);
        chk("vec first awlen", aw_log_len[aw0], vt[i].first_awlen);
      end
    end

    // FIFO threshold: 63 words must not start a 64-beat burst, 64 must.
    base_addr = 32'h0050_0000;
    line_stride = 16'h0800;
    line_beats = 16'd64;
    frame_lines = 16'd1;
    wr_mode = 1;
    aw_allow = 1'b0;
    fifo_mode = 1;
    fifo_fill = word + 63;
    fd0 = fd_count;
    p0 = pops;
    model_frame();
    pulse_frame();
    repeat (12) cyc();
    chk("awvalid with 63 words", axi_awvalid, 1'b0);
    fifo_fill = fifo_fill + 1;
    cyc();
    chk("awvalid with 64 words", axi_awvalid, 1'b1);
    aw_allow = 1'b1;
    wait_frames(fd0 + 1, "threshold frame timeout");
    chk("pops in 64-beat burst", pops - p0, 64);

    // enable low: frame loads but no burst is issued
    fifo_mode = 0;
    wr_mode = 0;
    enable = 1'b0;
    line_beats = 16'd2;
    aw0 = aw_log_addr.size();
    fd0 = fd_count;
    model_frame();
    pulse_frame();
    repeat (10) cyc();
    chk("no AW while disabled", aw_log_addr.size(), aw0);
    enable = 1'b1;
    wait_frames(fd0 + 1, "enable frame timeout");

    // reset in the middle of a data burst
    base_addr = 32'h0060_0000;
    line_beats = 16'd64;
    wr_mode = 1;
    p0 = pops;
    model_frame();
    pulse_frame();
    n = 0;
    while (pops < p0 + 3 && n < 500) begin
      cyc();
      n++;
    end
    chk("reached data phase", pops >= p0 + 3, 1'b1);
    axi_resetn = 1'b0;
    #1;
    chk("midrst awvalid", axi_awvalid, 1'b0);
    chk("midrst wvalid", axi_wvalid, 1'b0);
    chk("midrst bready", axi_bready, 1'b0);
    chk("midrst fifo_rd_en", fifo_rd_en, 1'b0);
    chk("midrst buf_idx", buf_idx, 3'd2);
    exp_q.delete();
    model_idx = 2;
    cyc();
    cyc();
    axi_resetn = 1'b1;
    cyc();

    // error response on the second burst of a frame
    base_addr = 32'h0070_0000;
    line_stride = 16'h1000;
    line_beats = 16'd100;
    frame_lines = 16'd2;
    wr_mode = 2;
    err_at = b_count + 1;
    fd0 = fd_count;
    chk("wr_err before error", wr_err, 1'b0);
    model_frame();
    pulse_frame();
    wait_frames(fd0 + 1, "error frame timeout");
    chk("wr_err after bresp error", wr_err, 1'b1);
    chk("buf_idx after reset", buf_idx, 3'd0);
    err_at = -1;

    // randomized frames
    fifo_mode = 2;
    aw_rand = 1'b1;
    b_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      base_addr = $urandom & 32'hFFFF_FFE0;
      frame_size = $urandom & 32'h00FF_FFE0;
      line_stride = 16'($urandom_range(0, 400) * 32);
      line_beats = 16'($urandom_range(1, 150));
      frame_lines = 16'($urandom_range(1, 3));
      wr_mode = $urandom_range(0, 2);
      fd0 = fd_count;
      model_frame();
      pulse_frame();
      wait_frames(fd0 + 1, "random frame timeout");
      chk("random bursts drained", exp_q.size(), 0);
      chk("random buf_idx", buf_idx, 3'(model_idx));
    end
    chk("wr_err sticky", wr_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
